// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: one GROUP-bit lookahead group per stage, carry registered
// between stages, with a global valid/ready advance shared by every stage.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N = WIDTH / GROUP;

  // Fully expanded lookahead carries c[0..GROUP] for one group; c[0] is the group carry-in.
  function automatic logic [GROUP:0] cla_carry(input logic [GROUP-1:0] a,
                                               input logic [GROUP-1:0] b,
                                               input logic             c0);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             term;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = c0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      term = c0;
      for (int unsigned j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             adv;
  logic [WIDTH-1:0] a_q [N];
  logic [WIDTH-1:0] b_q [N];
  logic [WIDTH-1:0] s_q [N];
  logic             c_q [N];
  logic             v_q [N];
  logic             ovf_q;

  logic [WIDTH-1:0] a_d [N];
  logic [WIDTH-1:0] b_d [N];
  logic [WIDTH-1:0] s_d [N];
  logic             c_d [N];
  logic             v_d [N];
  logic             ovf_d;

  assign adv = !v_q[N-1] | out_ready;

  for (genvar s = 0; s < N; s++) begin : g_stage
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
    logic             src_v;
    logic [GROUP-1:0] ga;
    logic [GROUP-1:0] gb;
    logic [GROUP:0]   cc;
    logic [WIDTH-1:0] nxt_s;

    if (s == 0) begin : g_first
      assign src_a = in1;
      assign src_b = in2;
      assign src_s = '0;
      assign src_c = cin;
      assign src_v = in_valid;
    end else begin : g_next
      assign src_a = a_q[s-1];
      assign src_b = b_q[s-1];
      assign src_s = s_q[s-1];
      assign src_c = c_q[s-1];
      assign src_v = v_q[s-1];
    end

    assign ga = src_a[s*GROUP +: GROUP];
    assign gb = src_b[s*GROUP +: GROUP];
    assign cc = cla_carry(ga, gb, src_c);

    always_comb begin
      nxt_s = src_s;
      nxt_s[s*GROUP +: GROUP] = ga ^ gb ^ cc[GROUP-1:0];
    end

    assign a_d[s] = src_a;
    assign b_d[s] = src_b;
    assign s_d[s] = nxt_s;
    assign c_d[s] = cc[GROUP];
    assign v_d[s] = src_v;

    // Carry into the MSB lives only inside the last group.
    if (s == N - 1) begin : g_ovf
      assign ovf_d = cc[GROUP-1] ^ cc[GROUP];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < N; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
        c_q[s] <= 1'b0;
        v_q[s] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned s = 0; s < N; s++) begin
        a_q[s] <= a_d[s];
        b_q[s] <= b_d[s];
        s_q[s] <= s_d[s];
        c_q[s] <= c_d[s];
        v_q[s] <= v_d[s];
      end
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[N-1];
  assign sum       = s_q[N-1];
  assign cout      = c_q[N-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: three instances (16/4, 8/8, 32/4) checked against an
// arithmetic scoreboard every cycle, plus directed latency, backpressure and reset scenarios.
module tb_pipelined_cla_adder;

  localparam int W [3]   = '{16, 8, 32};
  localparam int LAT [3] = '{4, 1, 8};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv [3];
  logic        ord [3];
  logic        cinv [3];
  logic [31:0] a [3];
  logic [31:0] b [3];
  logic        ir [3];
  logic        ov [3];
  logic        co [3];
  logic        of [3];
  logic [31:0] sm [3];
  logic [15:0] sum0;
  logic [7:0]  sum1;
  logic [31:0] sum2;

  always_comb begin
    sm[0] = 32'(sum0);
    sm[1] = 32'(sum1);
    sm[2] = sum2;
  end

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in1(a[0][15:0]),
    .in2(b[0][15:0]), .cin(cinv[0]), .out_valid(ov[0]), .out_ready(ord[0]), .sum(sum0),
    .cout(co[0]), .ovf(of[0])
  );
  pipelined_cla_adder #(.WIDTH(8), .GROUP(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in1(a[1][7:0]),
    .in2(b[1][7:0]), .cin(cinv[1]), .out_valid(ov[1]), .out_ready(ord[1]), .sum(sum1),
    .cout(co[1]), .ovf(of[1])
  );
  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in1(a[2]),
    .in2(b[2]), .cin(cinv[2]), .out_valid(ov[2]), .out_ready(ord[2]), .sum(sum2),
    .cout(co[2]), .ovf(of[2])
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  logic [33:0] sbq [3][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int l);
    return 32'((64'h1 << W[l]) - 64'h1);
  endfunction

  // Reference: plain integer addition, signed overflow = same-sign operands, other-sign result.
  function automatic logic [33:0] model(input int l, input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [63:0] s;
    logic [31:0] m;
    int          w;
    logic        ov_bit;
    w = W[l];
    m = mask_of(l);
    s = 64'(x & m) + 64'(y & m) + 64'(c);
    ov_bit = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {ov_bit, s[w], s[31:0] & m};
  endfunction

  // Single compare process: every cycle, every lane.
  initial begin
    logic        dlv [3];
    logic        acc [3];
    logic [33:0] nxt [3];
    logic [33:0] e;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        dlv[l] = 1'b0;
        acc[l] = 1'b0;
        if (mon_en) begin
          chk($sformatf("in_ready_l%0d", l), 32'(ir[l]), 32'(!ov[l] | ord[l]));
          if (ov[l]) begin
            if (sbq[l].size() == 0) begin
              chk($sformatf("stale_out_valid_l%0d", l), 32'(ov[l]), 32'(0));
            end else begin
              e = sbq[l][0];
              chk($sformatf("sum_l%0d", l), sm[l], e[31:0]);
              chk($sformatf("cout_l%0d", l), 32'(co[l]), 32'(e[32]));
              chk($sformatf("ovf_l%0d", l), 32'(of[l]), 32'(e[33]));
            end
          end
          dlv[l] = ov[l] & ord[l];
          acc[l] = iv[l] & ir[l];
          nxt[l] = model(l, a[l], b[l], cinv[l]);
        end
      end
      @(posedge clk);
      for (int l = 0; l < 3; l++) begin
        if (mon_en) begin
          if (!rst_n) begin
            sbq[l].delete();
          end else begin
            if (dlv[l] && sbq[l].size() > 0) void'(sbq[l].pop_front());
            if (acc[l]) sbq[l].push_back(nxt[l]);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sbq[0].size() + sbq[1].size() + sbq[2].size() == 0) break;
      tick();
    end
    for (int l = 0; l < 3; l++) chk($sformatf("drain_empty_l%0d", l), 32'(sbq[l].size()), 0);
  endtask

  // One beat into an empty pipe; checks exact latency and hand-computed result.
  task automatic one_beat(input int l, input logic [31:0] x, input logic [31:0] y, input logic c,
                          input logic [31:0] es, input logic ec, input logic eo, input string nm);
    a[l] = x; b[l] = y; cinv[l] = c; iv[l] = 1'b1; ord[l] = 1'b1;
    tick();
    iv[l] = 1'b0;
    for (int k = 0; k < LAT[l] - 1; k++) begin
      chk({nm, "_early_valid"}, 32'(ov[l]), 0);
      tick();
    end
    chk({nm, "_valid"}, 32'(ov[l]), 1);
    chk({nm, "_sum"}, sm[l], es);
    chk({nm, "_cout"}, 32'(co[l]), 32'(ec));
    chk({nm, "_ovf"}, 32'(of[l]), 32'(eo));
    tick();
  endtask

  task automatic bp_phase(input int first, input int nbeats, input bit do_reset);
    int          p = 0;
    logic        took;
    logic [31:0] held;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      ord[0]  = !(c >= 6 && c <= 8);
      rst_n   = !(do_reset && c == 12);
      iv[0]   = (p < nbeats);
      a[0]    = ((first + p) * 32'h3D09) & 32'hFFFF;
      b[0]    = ((first + p) * 32'h7F4B + 32'h8001) & 32'hFFFF;
      cinv[0] = p[0];
      #1;
      if (c >= 6 && c <= 8) begin
        chk("bp_in_ready_low", 32'(ir[0]), 0);
        chk("bp_out_valid_held", 32'(ov[0]), 1);
        if (c == 6) held = sm[0];
        else chk("bp_sum_held", sm[0], held);
      end
      took = iv[0] & ir[0] & rst_n;
      tick();
      if (took) p++;
      if (do_reset && c == 12) chk("rst_mid_out_valid", 32'(ov[0]), 0);
    end
    rst_n = 1'b1;
    iv[0] = 1'b0;
    ord[0] = 1'b1;
  endtask

  task automatic rand_stream(input int l, input int nbeats);
    int   sent = 0;
    logic took;
    iv[l] = 1'b0;
    while (sent < nbeats) begin
      if (!iv[l] && $urandom_range(0, 3) != 0) begin
        iv[l]   = 1'b1;
        a[l]    = $urandom() & mask_of(l);
        b[l]    = $urandom() & mask_of(l);
        cinv[l] = 1'($urandom_range(0, 1));
      end
      ord[l] = ($urandom_range(0, 3) != 0);
      #1;
      took = iv[l] & ir[l];
      tick();
      if (took) begin
        sent++;
        iv[l] = 1'b0;
      end
    end
    iv[l] = 1'b0;
    ord[l] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int l = 0; l < 3; l++) begin
      iv[l] = 1'b1; ord[l] = 1'b1; cinv[l] = 1'b1; a[l] = 32'hFFFF_FFFF; b[l] = 32'h1;
    end
    tick();
    tick();
    mon_en = 1'b1;
    chk("rst_out_valid", 32'(ov[0]), 0);
    chk("rst_sum", sm[0], 0);
    chk("rst_cout", 32'(co[0]), 0);
    chk("rst_ovf", 32'(of[0]), 0);
    chk("rst_in_ready", 32'(ir[0]), 1);
    rst_n = 1'b1;
    for (int l = 0; l < 3; l++) iv[l] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_no_output", 32'(ov[0]), 0);
    end

    one_beat(0, 32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, 1'b0, "carry_chain");
    one_beat(0, 32'hFFFF, 32'hFFFF, 1'b1, 32'hFFFF, 1'b1, 1'b0, "all_ones");
    one_beat(0, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1, "pos_ovf");
    one_beat(0, 32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 1'b1, "neg_ovf");
    one_beat(1, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, "lat1");
    one_beat(2, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, "lat8");

    for (int j = 0; j < 14; j++) begin
      iv[0] = (j < 8); a[0] = 32'(j) * 32'h1111; b[0] = 32'h0F0F; cinv[0] = 1'(j & 1);
      tick();
      chk("stream_valid", 32'(ov[0]), 32'(j >= 3 && j <= 10));
      if (j == 3) begin
        chk("stream_first_sum", sm[0], 32'h0F0F);
        chk("stream_first_ovf", 32'(of[0]), 0);
      end
      if (j == 10) begin
        chk("stream_last_sum", sm[0], 32'h8687);
        chk("stream_last_cout", 32'(co[0]), 0);
        chk("stream_last_ovf", 32'(of[0]), 1);
      end
    end
    drain();

    bp_phase(0, 20, 1'b0);
    drain();
    bp_phase(100, 20, 1'b1);
    drain();

    fork
      rand_stream(1, 1000);
      rand_stream(2, 1000);
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

- Parametrised, pipelined carry-lookahead adder for wide operands. It is the successor to the fixed 4-bit CLA.
- The operands are split into GROUP-bit lookahead groups, one pipeline stage per group, with the carry rippling between stages through registers.
- A valid/ready handshake on both sides lets it sit directly in datapath streams.
- It adds signed-overflow detection and backpressure handling.

## Interface
Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP, ≥ GROUP.
- GROUP, 4, bits per carry-lookahead group; number of stages N = WIDTH/GROUP.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  adder accepts beat this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  (in1 + in2 + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow = carry into bit WIDTH-1 XOR cout.

## Operation
- Group g (0..N-1) covers bits [g*GROUP +: GROUP].
- Within a group, the sum is computed by carry-lookahead:
  - p = a^b, g = a&b.
  - c[i+1] = g[i] | p[i]&c[i], fully expanded (no intra-group ripple).
  - Group P/G outputs are not required.
- Stage k (1..N) registers:
  - the sum bits of groups 0..k-1;
  - the carry out of group k-1;
  - the unprocessed operand bits of groups k..N-1;
  - a valid bit.
- Stage 1 computes group 0 from in1/in2/cin. Stage k+1 computes group k from stage-k operands and carry.
- Stage N registers drive sum, cout, ovf and out_valid. ovf uses the carry into the MSB, captured in the last group.
- Global advance: adv = !out_valid | out_ready; in_ready = adv.
  - When adv=1, every stage loads from its predecessor. Stage 1 loads in_valid and the input operands.
  - When adv=0, all stages hold.
- Bubbles are not collapsed; a bubble occupies its slot.
- Beat accepted iff in_valid & in_ready. Beat delivered iff out_valid & out_ready.
- Results leave in acceptance order, one per accepted beat, no loss or duplication.
- in_valid=1 while in_ready=0 is ignored. The source must hold the beat (AXI-style).
- Operand data of invalid stages is don't-care. The sum/cout/ovf registers still load on adv, so outputs are defined only when out_valid=1.

## Timing
- Reset (rst_n=0 at a rising edge) clears:
  - all stage valid bits;
  - all data registers to 0.
- After reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Reset takes priority over adv. Beats in flight during reset are discarded; nothing is emitted for them.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+N-1, i.e. N cycles, provided out_ready stays high.
- Throughput: 1 beat/cycle with out_ready=1.
- Backpressure:
  - When out_valid=1 and out_ready=0, in_ready drops combinationally in the same cycle.
  - The outputs are held stable until the delivering edge.
- in_ready depends combinationally on out_ready and out_valid only; there is no path from in_valid.
- Simultaneous accept and deliver in one cycle is legal and required at full rate.
- N=1 (GROUP=WIDTH) degenerates to a single registered CLA with latency 1.

## Test plan
Defaults WIDTH=16, GROUP=4 (N=4) unless stated.
- Reset: hold rst_n=0 for 2 cycles with in_valid=1.
  - Required: out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1.
  - No output appears 4 cycles after release unless beats are sent after release.
- Full carry chain: 0xFFFF+0x0000, cin=1, out_ready=1.
  - Required: exactly 4 cycles later, sum=0x0000, cout=1, ovf=0.
  - Then 0xFFFF+0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0.
- Signed overflow: 0x7FFF+0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
  - Also 0x8000+0x8000, cin=0 → sum=0x0000, cout=1, ovf=1.
- Streaming: 8 back-to-back beats (A=i*0x1111, B=0x0F0F, cin=i&1, i=0..7).
  - Required: 8 consecutive out_valid cycles starting at cycle 4, correct, in order.
- Backpressure plus reset mid-flight:
  - Fill the pipe, then hold out_ready=0 for 3 cycles.
  - Required: in_ready=0, sum/cout held, no drop or duplicate after release.
  - Repeat, then assert rst_n=0 for 1 cycle mid-stream. Required: out_valid=0 next cycle, no stale result ever emitted.
- Parameter sweep: WIDTH=8, GROUP=8 (latency 1) and WIDTH=32, GROUP=4 (latency 8).
  - Required: 1000 random beats with random out_ready match a reference model (A+B+cin, overflow rule) bit-exact.
